// File: rtl/dct_vecrot_arb.sv
// Frame-level round-robin arbiter in front of the single-buffered DCT vecRot RAM stage.
// Grants whole frames, repairs frame length to N/2+1 beats and holds off until read-out completes.
module dct_vecrot_arb #(
  parameter int wData   = 16,
  parameter int PTS_MIN = 8,
  parameter int PTS_MAX = 2048
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             ch0_valid,
  output logic             ch0_ready,
  input  logic             ch0_sop,
  input  logic             ch0_eop,
  input  logic [wData-1:0] ch0_real,
  input  logic [wData-1:0] ch0_imag,
  input  logic [11:0]      ch0_fftpts,
  input  logic             ch1_valid,
  output logic             ch1_ready,
  input  logic             ch1_sop,
  input  logic             ch1_eop,
  input  logic [wData-1:0] ch1_real,
  input  logic [wData-1:0] ch1_imag,
  input  logic [11:0]      ch1_fftpts,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic [wData-1:0] m_real,
  output logic [wData-1:0] m_imag,
  output logic [11:0]      m_fftpts,
  input  logic             m_done,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             err_len,
  output logic             err_pts,
  output logic             err_stray
);

  typedef enum logic [1:0] {IDLE, XFER, FLUSH, DRAIN} state_t;

  state_t      state_reg;
  logic [1:0]  grant_reg;
  logic        last_reg;
  logic [11:0] cnt_reg;
  logic [11:0] pts_reg;
  logic        fwd_reg;
  logic        err_len_reg, err_pts_reg, err_stray_reg;

  logic [1:0]       ch_valid, ch_sop, ch_eop, ch_ready, req, stray;
  logic [wData-1:0] ch_real [2];
  logic [wData-1:0] ch_imag [2];
  logic [11:0]      ch_pts  [2];

  assign ch_valid   = {ch1_valid, ch0_valid};
  assign ch_sop     = {ch1_sop, ch0_sop};
  assign ch_eop     = {ch1_eop, ch0_eop};
  assign ch_real[0] = ch0_real;
  assign ch_real[1] = ch1_real;
  assign ch_imag[0] = ch0_imag;
  assign ch_imag[1] = ch1_imag;
  assign ch_pts[0]  = ch0_fftpts;
  assign ch_pts[1]  = ch1_fftpts;
  assign ch0_ready  = ch_ready[0];
  assign ch1_ready  = ch_ready[1];

  logic        sel;
  logic        g_valid, g_sop, g_eop, beat;
  logic        win, pts_ok, last_beat;
  logic [11:0] pts_new, expected, cnt_inc;

  assign sel     = grant_reg[1];
  assign g_valid = ch_valid[sel];
  assign g_sop   = ch_sop[sel];
  assign g_eop   = ch_eop[sel];

  assign req   = ch_valid & ch_sop;
  assign stray = ch_valid & ~ch_sop;
  // last_reg holds the previous winner, so a tie goes to the other channel
  assign win     = req[1] && (!req[0] || !last_reg);
  assign pts_new = win ? ch_pts[1] : ch_pts[0];
  assign pts_ok  = (pts_new >= 12'(PTS_MIN)) && (pts_new <= 12'(PTS_MAX)) &&
                   ((pts_new & (pts_new - 12'd1)) == 12'd0);

  assign expected  = {1'b0, pts_reg[11:1]} + 12'd1;
  assign cnt_inc   = cnt_reg + 12'd1;
  assign last_beat = (cnt_inc == expected);
  assign beat      = (state_reg == XFER) && g_valid && m_ready;

  always_comb begin
    ch_ready = 2'b00;
    m_valid  = 1'b0;
    m_sop    = 1'b0;
    m_eop    = 1'b0;
    m_real   = '0;
    m_imag   = '0;
    case (state_reg)
      IDLE:  ch_ready = stray;
      XFER: begin
        m_valid       = g_valid;
        m_sop         = g_valid && g_sop && (cnt_reg == 12'd0);
        m_eop         = g_valid && (g_eop || last_beat);
        m_real        = ch_real[sel];
        m_imag        = ch_imag[sel];
        ch_ready[sel] = m_ready;
      end
      FLUSH: ch_ready[sel] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_reg     <= IDLE;
      grant_reg     <= 2'b00;
      last_reg      <= 1'b1;
      cnt_reg       <= '0;
      pts_reg       <= '0;
      fwd_reg       <= 1'b0;
      err_len_reg   <= 1'b0;
      err_pts_reg   <= 1'b0;
      err_stray_reg <= 1'b0;
    end else begin
      err_len_reg   <= 1'b0;
      err_pts_reg   <= 1'b0;
      err_stray_reg <= (state_reg == IDLE) && (|stray);
      case (state_reg)
        IDLE: if (|req) begin
          grant_reg <= win ? 2'b10 : 2'b01;
          last_reg  <= win;
          pts_reg   <= pts_new;
          cnt_reg   <= '0;
          fwd_reg   <= 1'b0;
          if (pts_ok) state_reg <= XFER;
          else begin
            err_pts_reg <= 1'b1;
            state_reg   <= FLUSH;
          end
        end
        XFER: if (beat) begin
          cnt_reg <= cnt_inc;
          fwd_reg <= 1'b1;
          if (g_eop) begin
            err_len_reg <= !last_beat;
            state_reg   <= DRAIN;
          end else if (last_beat) begin
            err_len_reg <= 1'b1;
            state_reg   <= FLUSH;
          end
        end
        FLUSH: if (g_valid && g_eop) begin
          if (fwd_reg) state_reg <= DRAIN;
          else begin
            state_reg <= IDLE;
            grant_reg <= 2'b00;
            pts_reg   <= '0;
          end
        end
        DRAIN: if (m_done) begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
          pts_reg   <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant     = grant_reg;
  assign busy      = (state_reg != IDLE);
  assign m_fftpts  = pts_reg;
  assign err_len   = err_len_reg;
  assign err_pts   = err_pts_reg;
  assign err_stray = err_stray_reg;

endmodule
